bsg_dmc_trace_to_ui_burst_adapter: RTL and testbench

Converts a valid/ready stream of DMC trace packets into the Xilinx-style UI command and write-data channels of the DMC controller, for any power-of-two burst length. Returns UI read data to the consumer through a credit-protected FIFO with valid/ready backpressure. Sits between the trace replay/FPGA link and `bsg_dmc`, replacing the fixed-width single-burst adapter.

---
 rtl/bsg_dmc_trace_to_ui_burst_adapter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_bsg_dmc_trace_to_ui_burst_adapter.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_dmc_trace_to_ui_burst_adapter.sv
//------------------------------------------------------------------------------
// bsg_dmc_trace_to_ui_burst_adapter
//
// Purpose:
//   Converts a valid/ready stream of DMC trace packets into the UI command and
//   write-data channels of the DMC controller, for any power-of-two burst
//   length. UI read data returns to the consumer through a FIFO. Read commands
//   reserve FIFO space (credits) before they issue, so the FIFO cannot overflow.
//
// Ports:
//   core_clk_i, core_reset_i     : clock and asynchronous active-high reset
//   trace_data_i/_v_i/_ready_o   : trace packet stream. MSB set = command
//                                  packet {cmd[2:0], addr}. MSB clear = write
//                                  data packet {wdata, wmask}.
//   app_addr_o/_cmd_o/_en_o,
//   app_rdy_i                    : UI command channel
//   app_wdf_*                    : UI write-data channel
//   app_rd_data_valid_i/_i/_end_i: UI read return
//   rd_data_o/_last_o/_v_o,
//   rd_yumi_i                    : consumer read return (valid/yumi)
//   error_o                      : sticky protocol error
//
// Command encodings on app_cmd_o:
//   WR = 3'b000, RD = 3'b001, RP = 3'b010, WP = 3'b011
//------------------------------------------------------------------------------
module bsg_dmc_trace_to_ui_burst_adapter
  #(parameter int data_width_p = 32
   ,parameter int addr_width_p = 28
   ,parameter int burst_len_p = 4
   ,parameter int rd_fifo_els_p = 8
   ,localparam int mask_width_lp = data_width_p >> 3
   ,localparam int payload_width_lp = data_width_p + mask_width_lp + 1
   )
  (input  logic                        core_clk_i
  ,input  logic                        core_reset_i

  ,input  logic [payload_width_lp-1:0] trace_data_i
  ,input  logic                        trace_v_i
  ,output logic                        trace_ready_o

  ,output logic [addr_width_p-1:0]     app_addr_o
  ,output logic [2:0]                  app_cmd_o
  ,output logic                        app_en_o
  ,input  logic                        app_rdy_i

  ,output logic                        app_wdf_wren_o
  ,output logic [data_width_p-1:0]     app_wdf_data_o
  ,output logic [mask_width_lp-1:0]    app_wdf_mask_o
  ,output logic                        app_wdf_end_o
  ,input  logic                        app_wdf_rdy_i

  ,input  logic                        app_rd_data_valid_i
  ,input  logic [data_width_p-1:0]     app_rd_data_i
  ,input  logic                        app_rd_data_end_i

  ,output logic [data_width_p-1:0]     rd_data_o
  ,output logic                        rd_last_o
  ,output logic                        rd_v_o
  ,input  logic                        rd_yumi_i

  ,output logic                        error_o
  );

  localparam int beat_width_lp = $clog2(burst_len_p);
  localparam int res_width_lp  = $clog2(rd_fifo_els_p + 1);
  localparam int ptr_width_lp  = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;

  // A read may issue only while at most this many entries are reserved, i.e.
  // while at least one full burst of FIFO space is unclaimed.
  localparam logic [res_width_lp-1:0] res_limit_lp  = res_width_lp'(rd_fifo_els_p - burst_len_p);
  localparam logic [res_width_lp-1:0] burst_res_lp  = res_width_lp'(burst_len_p);
  localparam logic [res_width_lp-1:0] fifo_full_lp  = res_width_lp'(rd_fifo_els_p);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp   = ptr_width_lp'(rd_fifo_els_p - 1);
  localparam logic [beat_width_lp-1:0] beat_last_lp = beat_width_lp'(burst_len_p - 1);

  localparam logic [2:0] cmd_wr_lp = 3'b000;
  localparam logic [2:0] cmd_rd_lp = 3'b001;
  localparam logic [2:0] cmd_rp_lp = 3'b010;
  localparam logic [2:0] cmd_wp_lp = 3'b011;

  localparam logic [1:0] state_idle = 2'd0;
  localparam logic [1:0] state_cmd  = 2'd1;
  localparam logic [1:0] state_wdata = 2'd2;

  // Packet field decode
  logic                    pkt_is_cmd;
  logic [2:0]              pkt_cmd;
  logic [addr_width_p-1:0] pkt_addr;

  assign pkt_is_cmd = trace_data_i[payload_width_lp-1];
  assign pkt_cmd    = trace_data_i[addr_width_p+2:addr_width_p];
  assign pkt_addr   = trace_data_i[addr_width_p-1:0];

  // Control state
  logic [1:0]              state_r;
  logic [2:0]              cmd_r;
  logic [addr_width_p-1:0] addr_r;
  logic [beat_width_lp-1:0] beat_r;
  logic [res_width_lp-1:0] reserved_r;
  logic [res_width_lp-1:0] reserved_n;
  logic                    error_r;

  // Read FIFO state
  logic [data_width_p:0]   mem_r [rd_fifo_els_p];
  logic [ptr_width_lp-1:0] wptr_r;
  logic [ptr_width_lp-1:0] rptr_r;
  logic [res_width_lp-1:0] count_r;
  logic                    fifo_full;

  logic cmd_is_read;
  logic cmd_is_write;
  logic credit_avail;
  logic last_beat;
  logic trace_fire;
  logic cmd_fire;
  logic beat_fire;
  logic reserve;
  logic push;
  logic pop;
  logic drop_err;

  assign cmd_is_read  = (cmd_r == cmd_rd_lp) | (cmd_r == cmd_rp_lp);
  assign cmd_is_write = (cmd_r == cmd_wr_lp) | (cmd_r == cmd_wp_lp);
  assign credit_avail = (reserved_r <= res_limit_lp);
  assign last_beat    = (beat_r == beat_last_lp);

  // Handshake strobes for the trace stream and both UI channels.
  always_comb begin
    trace_ready_o  = 1'b0;
    app_en_o       = 1'b0;
    app_wdf_wren_o = 1'b0;
    case (state_r)
      state_idle: begin
        trace_ready_o = 1'b1;
      end
      state_cmd: begin
        // Reads wait here until a whole burst of FIFO space is unclaimed.
        app_en_o = ~cmd_is_read | credit_avail;
      end
      state_wdata: begin
        trace_ready_o  = app_wdf_rdy_i;
        app_wdf_wren_o = trace_v_i & ~pkt_is_cmd;
      end
      default: begin
        trace_ready_o = 1'b0;
      end
    endcase
  end

  // Write data passes straight through so beats add no latency; it is forced
  // to zero whenever no beat is being presented.
  assign app_wdf_data_o = app_wdf_wren_o ? trace_data_i[payload_width_lp-2:mask_width_lp] : '0;
  assign app_wdf_mask_o = app_wdf_wren_o ? trace_data_i[mask_width_lp-1:0] : '0;
  assign app_wdf_end_o  = app_wdf_wren_o & last_beat;

  assign app_addr_o = addr_r;
  assign app_cmd_o  = cmd_r;
  assign error_o    = error_r;

  assign trace_fire = trace_v_i & trace_ready_o;
  assign cmd_fire   = app_en_o & app_rdy_i;
  assign beat_fire  = app_wdf_wren_o & app_wdf_rdy_i;
  assign reserve    = cmd_fire & cmd_is_read;
  assign push       = app_rd_data_valid_i;
  assign pop        = rd_yumi_i & rd_v_o;

  // A data packet with no open write, or a command packet in the middle of a
  // write burst, is consumed and dropped and flags the error.
  assign drop_err = trace_fire & (((state_r == state_idle) & ~pkt_is_cmd)
                                | ((state_r == state_wdata) & pkt_is_cmd));

  // Main FSM: latch a command, hand it to the UI, then count write beats.
  always_ff @(posedge core_clk_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_r <= state_idle;
      cmd_r   <= '0;
      addr_r  <= '0;
      beat_r  <= '0;
      error_r <= 1'b0;
    end else begin
      if (drop_err) begin
        error_r <= 1'b1;
      end
      case (state_r)
        state_idle: begin
          if (trace_fire & pkt_is_cmd) begin
            cmd_r   <= pkt_cmd;
            addr_r  <= pkt_addr;
            state_r <= state_cmd;
          end
        end
        state_cmd: begin
          if (cmd_fire) begin
            beat_r  <= '0;
            state_r <= cmd_is_write ? state_wdata : state_idle;
          end
        end
        state_wdata: begin
          if (beat_fire) begin
            if (last_beat) begin
              beat_r  <= '0;
              state_r <= state_idle;
            end else begin
              beat_r <= beat_r + beat_width_lp'(1);
            end
          end
        end
        default: begin
          state_r <= state_idle;
        end
      endcase
    end
  end

  // Reservation counter: a read claims a full burst when it issues, and each
  // consumer pop hands one entry back. Both may happen in the same cycle.
  always_comb begin
    reserved_n = reserved_r;
    if (reserve) begin
      reserved_n = reserved_n + burst_res_lp;
    end
    if (pop) begin
      reserved_n = reserved_n - res_width_lp'(1);
    end
  end

  always_ff @(posedge core_clk_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      reserved_r <= '0;
    end else begin
      reserved_r <= reserved_n;
    end
  end

  // Read FIFO storage. Entries carry the end-of-burst bit above the data.
  assign fifo_full = (count_r == fifo_full_lp);

  always_ff @(posedge core_clk_i) begin
    if (push & ~fifo_full) begin
      mem_r[wptr_r] <= {app_rd_data_end_i, app_rd_data_i};
    end
  end

  // FIFO pointers wrap explicitly so depths that are not a power of two work.
  always_ff @(posedge core_clk_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push & ~fifo_full) begin
        wptr_r <= (wptr_r == ptr_last_lp) ? '0 : wptr_r + ptr_width_lp'(1);
      end
      if (pop) begin
        rptr_r <= (rptr_r == ptr_last_lp) ? '0 : rptr_r + ptr_width_lp'(1);
      end
      count_r <= count_r + res_width_lp'(push & ~fifo_full) - res_width_lp'(pop);
    end
  end

  // Outputs read as zero while the FIFO is empty so unwritten storage never
  // leaks out.
  assign rd_v_o    = (count_r != '0);
  assign rd_data_o = rd_v_o ? mem_r[rptr_r][data_width_p-1:0] : '0;
  assign rd_last_o = rd_v_o ? mem_r[rptr_r][data_width_p] : 1'b0;

`ifndef SYNTHESIS
  // Credits make overflow impossible and the consumer must only pop valid
  // data; either event means a broken protocol upstream.
  always_ff @(posedge core_clk_i) begin
    if (!core_reset_i) begin
      assert (!(push && fifo_full));
      assert (!(rd_yumi_i && !rd_v_o));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_dmc_trace_to_ui_burst_adapter.sv
//------------------------------------------------------------------------------
// tb_bsg_dmc_trace_to_ui_burst_adapter
//
// Drives randomized trace packets and UI read returns into the adapter and
// compares against a behavioural model: a credit count (free = depth -
// reserved), a queue of expected read-return entries and per-burst arrays of
// the write beats that were sent.
//------------------------------------------------------------------------------
module tb_bsg_dmc_trace_to_ui_burst_adapter;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int BL = 4;
  localparam int DEPTH = 8;
  localparam int MW = DW >> 3;
  localparam int PW = DW + MW + 1;

  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] RP = 3'b010;
  localparam logic [2:0] WP = 3'b011;

  logic          core_clk_i = 1'b0;
  logic          core_reset_i;
  logic [PW-1:0] trace_data_i;
  logic          trace_v_i;
  logic          trace_ready_o;
  logic [AW-1:0] app_addr_o;
  logic [2:0]    app_cmd_o;
  logic          app_en_o;
  logic          app_rdy_i;
  logic          app_wdf_wren_o;
  logic [DW-1:0] app_wdf_data_o;
  logic [MW-1:0] app_wdf_mask_o;
  logic          app_wdf_end_o;
  logic          app_wdf_rdy_i;
  logic          app_rd_data_valid_i;
  logic [DW-1:0] app_rd_data_i;
  logic          app_rd_data_end_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;
  logic          rd_v_o;
  logic          rd_yumi_i;
  logic          error_o;

  int errors = 0;
  int checks = 0;

  // Model state: entries the consumer has yet to receive, and FIFO space
  // claimed by issued reads.
  logic [DW:0] rq[$];
  int          reserved_m;

  bsg_dmc_trace_to_ui_burst_adapter
    #(.data_width_p(DW), .addr_width_p(AW), .burst_len_p(BL), .rd_fifo_els_p(DEPTH))
  dut
    (.core_clk_i(core_clk_i)
    ,.core_reset_i(core_reset_i)
    ,.trace_data_i(trace_data_i)
    ,.trace_v_i(trace_v_i)
    ,.trace_ready_o(trace_ready_o)
    ,.app_addr_o(app_addr_o)
    ,.app_cmd_o(app_cmd_o)
    ,.app_en_o(app_en_o)
    ,.app_rdy_i(app_rdy_i)
    ,.app_wdf_wren_o(app_wdf_wren_o)
    ,.app_wdf_data_o(app_wdf_data_o)
    ,.app_wdf_mask_o(app_wdf_mask_o)
    ,.app_wdf_end_o(app_wdf_end_o)
    ,.app_wdf_rdy_i(app_wdf_rdy_i)
    ,.app_rd_data_valid_i(app_rd_data_valid_i)
    ,.app_rd_data_i(app_rd_data_i)
    ,.app_rd_data_end_i(app_rd_data_end_i)
    ,.rd_data_o(rd_data_o)
    ,.rd_last_o(rd_last_o)
    ,.rd_v_o(rd_v_o)
    ,.rd_yumi_i(rd_yumi_i)
    ,.error_o(error_o)
    );

  always #5 core_clk_i = ~core_clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PW-1:0] make_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    logic [PW-1:0] p;
    p = '0;
    p[PW-1] = 1'b1;
    p[AW+2:AW] = c;
    p[AW-1:0] = a;
    return p;
  endfunction

  function automatic logic [PW-1:0] make_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    return {1'b0, d, m};
  endfunction

  function automatic logic credits_free();
    return (DEPTH - reserved_m) >= BL;
  endfunction

  // Inputs change at the falling edge; outputs are checked 1 ns later.
  task automatic tick();
    @(posedge core_clk_i);
    @(negedge core_clk_i);
  endtask

  task automatic send_packet(input logic [PW-1:0] pkt);
    trace_data_i = pkt;
    trace_v_i = 1'b1;
    tick();
    trace_v_i = 1'b0;
  endtask

  task automatic test_reset();
    core_reset_i = 1'b1;
    tick();
    #1;
    checks++;
    if (trace_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", trace_ready_o);
    end
    checks++;
    if ({app_en_o, app_wdf_wren_o, app_wdf_end_o, rd_v_o, rd_last_o, error_o} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000000",
                         {app_en_o, app_wdf_wren_o, app_wdf_end_o, rd_v_o, rd_last_o, error_o});
    end
    checks++;
    if ({app_addr_o, app_cmd_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_cmd: got addr %h cmd %h expected 0", app_addr_o, app_cmd_o);
    end
    checks++;
    if ({app_wdf_data_o, app_wdf_mask_o, rd_data_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got wdf %h mask %h rd %h expected 0",
                         app_wdf_data_o, app_wdf_mask_o, rd_data_o);
    end
    tick();
    core_reset_i = 1'b0;
    reserved_m = 0;
  endtask

  // One write command followed by its burst, with optional stall and gaps.
  task automatic write_burst(input logic [2:0] wcmd, input int stall_beat, input int stall_cycles);
    logic [AW-1:0] addr;
    logic [DW-1:0] d [BL];
    logic [MW-1:0] m [BL];
    int hold;
    addr = AW'($urandom);
    for (int i = 0; i < BL; i++) begin
      d[i] = $urandom;
      m[i] = MW'($urandom);
    end
    hold = $urandom_range(0, 2);
    trace_data_i = make_cmd(wcmd, addr);
    trace_v_i = 1'b1;
    app_rdy_i = 1'b0;
    app_wdf_rdy_i = 1'b1;
    #1;
    checks++;
    if (trace_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_cmd_ready: got %b expected 1", trace_ready_o);
    end
    tick();
    trace_v_i = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      app_rdy_i = (c == hold);
      #1;
      checks++;
      if ({app_en_o, app_cmd_o, app_addr_o} !== {1'b1, wcmd, addr}) begin
        errors++; $display("[TB] FAIL wr_cmd_issue: got en %b cmd %h addr %h expected en 1 cmd %h addr %h",
                           app_en_o, app_cmd_o, app_addr_o, wcmd, addr);
      end
      tick();
    end
    app_rdy_i = 1'b1;
    for (int b = 0; b < BL; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        trace_v_i = 1'b0;
        #1;
        checks++;
        if ({app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, app_wdf_mask_o} !== '0) begin
          errors++; $display("[TB] FAIL wr_gap: got wren %b end %b data %h mask %h expected all 0",
                             app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, app_wdf_mask_o);
        end
        tick();
      end
      for (int s = 0; b == stall_beat && s < stall_cycles; s++) begin
        trace_data_i = make_data(d[b], m[b]);
        trace_v_i = 1'b1;
        app_wdf_rdy_i = 1'b0;
        #1;
        checks++;
        if ({trace_ready_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, app_wdf_mask_o} !==
            {1'b0, 1'b1, (b == BL-1), d[b], m[b]}) begin
          errors++; $display("[TB] FAIL wr_stall beat %0d: got rdy %b wren %b end %b data %h mask %h expected rdy 0 wren 1 end %b data %h mask %h",
                             b, trace_ready_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, app_wdf_mask_o,
                             (b == BL-1), d[b], m[b]);
        end
        tick();
      end
      trace_data_i = make_data(d[b], m[b]);
      trace_v_i = 1'b1;
      app_wdf_rdy_i = 1'b1;
      #1;
      checks++;
      if ({app_en_o, trace_ready_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, app_wdf_mask_o} !==
          {1'b0, 1'b1, 1'b1, (b == BL-1), d[b], m[b]}) begin
        errors++; $display("[TB] FAIL wr_beat %0d: got en %b rdy %b wren %b end %b data %h mask %h expected en 0 rdy 1 wren 1 end %b data %h mask %h",
                           b, app_en_o, trace_ready_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o,
                           app_wdf_mask_o, (b == BL-1), d[b], m[b]);
      end
      tick();
    end
    // With the write-data channel stalled, only IDLE still reports ready.
    trace_v_i = 1'b0;
    app_wdf_rdy_i = 1'b0;
    #1;
    checks++;
    if ({trace_ready_o, app_en_o, app_wdf_wren_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL wr_back_idle: got rdy %b en %b wren %b expected 1 0 0",
                         trace_ready_o, app_en_o, app_wdf_wren_o);
    end
    tick();
    app_wdf_rdy_i = 1'b1;
  endtask

  task automatic test_write_burst();
    write_burst(WR, -1, 0);
    write_burst(WP, -1, 0);
  endtask

  task automatic test_write_stall();
    write_burst(WR, 1, 3);
  endtask

  task automatic test_read_credits();
    logic [2:0] c;
    logic [AW-1:0] a;
    logic exp_en;
    logic [DW-1:0] rdat;
    rd_yumi_i = 1'b0;
    app_rdy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c = ($urandom_range(0, 1) == 0) ? RD : RP;
      a = AW'($urandom);
      send_packet(make_cmd(c, a));
      exp_en = credits_free();
      #1;
      checks++;
      if ({app_en_o, app_cmd_o, app_addr_o} !== {exp_en, c, a}) begin
        errors++; $display("[TB] FAIL rd_issue %0d: got en %b cmd %h addr %h expected en %b cmd %h addr %h",
                           k, app_en_o, app_cmd_o, app_addr_o, exp_en, c, a);
      end
      tick();
      if (exp_en) reserved_m += BL;
    end
    // Third read is parked; return data for the first two.
    for (int i = 0; i < 2*BL; i++) begin
      rdat = $urandom;
      app_rd_data_valid_i = 1'b1;
      app_rd_data_i = rdat;
      app_rd_data_end_i = (i % BL == BL-1);
      #1;
      checks++;
      if ({app_en_o, rd_v_o} !== {credits_free(), (rq.size() > 0)}) begin
        errors++; $display("[TB] FAIL rd_fill %0d: got en %b v %b expected en %b v %b",
                           i, app_en_o, rd_v_o, credits_free(), (rq.size() > 0));
      end
      tick();
      rq.push_back({app_rd_data_end_i, rdat});
    end
    app_rd_data_valid_i = 1'b0;
    for (int p = 0; p < BL; p++) begin
      rd_yumi_i = 1'b1;
      #1;
      checks++;
      if ({app_en_o, rd_v_o, rd_last_o, rd_data_o} !== {credits_free(), 1'b1, rq[0]}) begin
        errors++; $display("[TB] FAIL rd_pop %0d: got en %b v %b last %b data %h expected en %b v 1 last %b data %h",
                           p, app_en_o, rd_v_o, rd_last_o, rd_data_o, credits_free(), rq[0][DW], rq[0][DW-1:0]);
      end
      tick();
      void'(rq.pop_front());
      reserved_m--;
    end
    rd_yumi_i = 1'b0;
    #1;
    checks++;
    if ({app_en_o, app_cmd_o, app_addr_o} !== {credits_free(), c, a}) begin
      errors++; $display("[TB] FAIL rd_unblock: got en %b cmd %h addr %h expected en %b cmd %h addr %h",
                         app_en_o, app_cmd_o, app_addr_o, credits_free(), c, a);
    end
    tick();
    reserved_m += BL;
  endtask

  task automatic test_read_return();
    int pushed;
    int delivered;
    int cyc;
    logic y;
    logic [DW-1:0] rdat;
    pushed = 0;
    delivered = 0;
    cyc = 0;
    while ((pushed < BL || rq.size() > 0) && cyc < 40) begin
      y = (cyc % 2 == 1) && (rq.size() > 0);
      rdat = $urandom;
      app_rd_data_valid_i = (pushed < BL);
      app_rd_data_i = rdat;
      app_rd_data_end_i = (pushed == BL-1);
      rd_yumi_i = y;
      #1;
      checks++;
      if (rd_v_o !== (rq.size() > 0)) begin
        errors++; $display("[TB] FAIL ret_valid cyc %0d: got %b expected %b", cyc, rd_v_o, (rq.size() > 0));
      end
      if (rq.size() > 0) begin
        checks++;
        if ({rd_last_o, rd_data_o} !== rq[0]) begin
          errors++; $display("[TB] FAIL ret_data %0d: got last %b data %h expected last %b data %h",
                             delivered, rd_last_o, rd_data_o, rq[0][DW], rq[0][DW-1:0]);
        end
        checks++;
        if (rd_last_o !== (delivered % BL == BL-1)) begin
          errors++; $display("[TB] FAIL ret_last %0d: got %b expected %b",
                             delivered, rd_last_o, (delivered % BL == BL-1));
        end
      end
      tick();
      if (y) begin
        void'(rq.pop_front());
        reserved_m--;
        delivered++;
      end
      if (app_rd_data_valid_i) begin
        rq.push_back({app_rd_data_end_i, rdat});
        pushed++;
      end
      cyc++;
    end
    app_rd_data_valid_i = 1'b0;
    rd_yumi_i = 1'b0;
    #1;
    checks++;
    if ({delivered, rd_v_o} !== {32'(2*BL), 1'b0}) begin
      errors++; $display("[TB] FAIL ret_count: got %0d beats v %b expected %0d beats v 0",
                         delivered, rd_v_o, 2*BL);
    end
    tick();
  endtask

  task automatic test_errors();
    logic [DW-1:0] d;
    // Stray data packet while idle.
    trace_data_i = make_data(32'hdeadbeef, 4'hf);
    trace_v_i = 1'b1;
    #1;
    checks++;
    if ({error_o, trace_ready_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL err_idle_pre: got err %b rdy %b expected 0 1", error_o, trace_ready_o);
    end
    tick();
    trace_v_i = 1'b0;
    #1;
    checks++;
    if ({error_o, app_en_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL err_idle_data: got err %b en %b expected 1 0", error_o, app_en_o);
    end
    tick();
    #1;
    checks++;
    if (error_o !== 1'b1) begin
      errors++; $display("[TB] FAIL err_sticky: got %b expected 1", error_o);
    end
    core_reset_i = 1'b1;
    #1;
    checks++;
    if (error_o !== 1'b0) begin
      errors++; $display("[TB] FAIL err_reset_clear: got %b expected 0", error_o);
    end
    tick();
    core_reset_i = 1'b0;
    reserved_m = 0;
    rq.delete();
    // Command packet in the middle of a write burst.
    app_rdy_i = 1'b1;
    app_wdf_rdy_i = 1'b1;
    send_packet(make_cmd(WR, AW'($urandom)));
    tick();
    for (int b = 0; b < BL; b++) begin
      if (b == 1) begin
        trace_data_i = make_cmd(RD, AW'($urandom));
        trace_v_i = 1'b1;
        #1;
        checks++;
        if ({app_wdf_wren_o, trace_ready_o, error_o} !== 3'b010) begin
          errors++; $display("[TB] FAIL err_wdata_cmd: got wren %b rdy %b err %b expected 0 1 0",
                             app_wdf_wren_o, trace_ready_o, error_o);
        end
        tick();
      end
      d = $urandom;
      trace_data_i = make_data(d, 4'h5);
      trace_v_i = 1'b1;
      #1;
      checks++;
      if ({error_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o} !== {(b >= 1), 1'b1, (b == BL-1), d}) begin
        errors++; $display("[TB] FAIL err_beat %0d: got err %b wren %b end %b data %h expected err %b wren 1 end %b data %h",
                           b, error_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o, (b >= 1), (b == BL-1), d);
      end
      tick();
    end
    trace_v_i = 1'b0;
    app_wdf_rdy_i = 1'b0;
    #1;
    checks++;
    if ({trace_ready_o, error_o} !== 2'b11) begin
      errors++; $display("[TB] FAIL err_after_burst: got rdy %b err %b expected 1 1", trace_ready_o, error_o);
    end
    tick();
    app_wdf_rdy_i = 1'b1;
  endtask

  task automatic test_reset_midburst();
    logic exp_en;
    app_rdy_i = 1'b1;
    app_wdf_rdy_i = 1'b1;
    // Tie up every credit so the reset has something to discard.
    for (int k = 0; k < 2; k++) begin
      send_packet(make_cmd(RD, AW'($urandom)));
      exp_en = credits_free();
      #1;
      checks++;
      if (app_en_o !== exp_en) begin
        errors++; $display("[TB] FAIL rst_pre_rd %0d: got en %b expected %b", k, app_en_o, exp_en);
      end
      tick();
      if (exp_en) reserved_m += BL;
    end
    send_packet(make_cmd(WR, AW'($urandom)));
    tick();
    for (int b = 0; b < BL; b++) begin
      trace_data_i = make_data($urandom, 4'ha);
      trace_v_i = 1'b1;
      #1;
      checks++;
      if ({app_wdf_wren_o, app_wdf_end_o} !== {1'b1, (b == BL-1)}) begin
        errors++; $display("[TB] FAIL rst_beat %0d: got wren %b end %b expected 1 %b",
                           b, app_wdf_wren_o, app_wdf_end_o, (b == BL-1));
      end
      if (b < BL-1) tick();
    end
    #1;
    core_reset_i = 1'b1;
    #1;
    checks++;
    if ({trace_ready_o, app_en_o, app_wdf_wren_o, app_wdf_end_o, error_o} !== 5'b10000) begin
      errors++; $display("[TB] FAIL rst_async_ctrl: got rdy %b en %b wren %b end %b err %b expected 1 0 0 0 0",
                         trace_ready_o, app_en_o, app_wdf_wren_o, app_wdf_end_o, error_o);
    end
    checks++;
    if ({app_addr_o, app_cmd_o, app_wdf_data_o, app_wdf_mask_o} !== '0) begin
      errors++; $display("[TB] FAIL rst_async_data: got addr %h cmd %h data %h mask %h expected 0",
                         app_addr_o, app_cmd_o, app_wdf_data_o, app_wdf_mask_o);
    end
    trace_v_i = 1'b0;
    tick();
    core_reset_i = 1'b0;
    reserved_m = 0;
    write_burst(WR, -1, 0);
    // Credits were discarded, so two reads issue immediately again.
    for (int k = 0; k < 2; k++) begin
      send_packet(make_cmd(RP, AW'($urandom)));
      exp_en = credits_free();
      #1;
      checks++;
      if (app_en_o !== exp_en) begin
        errors++; $display("[TB] FAIL rst_post_rd %0d: got en %b expected %b", k, app_en_o, exp_en);
      end
      tick();
      if (exp_en) reserved_m += BL;
    end
  endtask

  initial begin
    trace_data_i = '0;
    trace_v_i = 1'b0;
    app_rdy_i = 1'b1;
    app_wdf_rdy_i = 1'b1;
    app_rd_data_valid_i = 1'b0;
    app_rd_data_i = '0;
    app_rd_data_end_i = 1'b0;
    rd_yumi_i = 1'b0;
    core_reset_i = 1'b1;
    reserved_m = 0;
    @(negedge core_clk_i);
    $display("[TB] starting");
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_credits();
    test_read_return();
    test_errors();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
